// File: rtl/mult_job_sequencer.sv
// Operand FIFO plus issue FSM feeding mult32x32: one job in flight, start pulse,
// product capture on busy fall, single-entry result slot, stall timeout and job counter.
module mult_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_busy,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        timeout_err,
  output logic [15:0] jobs_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE    = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;
  localparam logic [CW-1:0] WAIT_ONE   = 1;
  localparam logic [CW-1:0] LAST_WAIT  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ARM, RUN} state_t;

  logic [63:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  state_t        state_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic          push, pop;

  // in_ready depends only on the registered count, so no path from the pop side.
  assign in_ready = (count_reg != FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state_reg == IDLE) && (count_reg != '0) && !out_valid;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      out_valid    <= 1'b0;
      out_product  <= '0;
      timeout_err  <= 1'b0;
      jobs_done    <= '0;
    end else begin
      mul_start <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        jobs_done <= jobs_done + 16'd1;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {mul_a, mul_b} <= fifo_mem[rd_ptr_reg];
            mul_start      <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_reg <= '0;
          state_reg    <= ARM;
        end
        ARM: begin
          if (mul_busy) begin
            wait_cnt_reg <= '0;
            state_reg    <= RUN;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            wait_cnt_reg <= '0;
            timeout_err  <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
          end
        end
        RUN: begin
          // Issue is gated on an empty slot, so this capture never collides with a pending result.
          if (!mul_busy) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state_reg   <= IDLE;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            wait_cnt_reg <= '0;
            timeout_err  <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Sits directly upstream of mult32x32 and feeds it operand jobs.
- Accepts operand pairs over a valid/ready stream into a small FIFO.
- Issues each job to mult32x32 with a start pulse and holds a/b stable while the multiplier runs.
- Captures the 64-bit product when busy falls and presents it on a valid/ready result port, with a stall timeout and a completed-job counter.

Parameters:
DEPTH, 4, operand FIFO depth in entries; power of two, at least 2.
TIMEOUT, 15, maximum cycles to wait in ARM or RUN before the job is abandoned.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full
in_a  in  32  operand a
in_b  in  32  operand b
mul_start  out  1  one-cycle start pulse to mult32x32
mul_a  out  32  operand a to mult32x32
mul_b  out  32  operand b to mult32x32
mul_busy  in  1  mult32x32 busy indication
mul_product  in  64  mult32x32 product
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  64  captured product
timeout_err  out  1  sticky: a job was abandoned
jobs_done  out  16  count of results handed off; wraps at 16 bits

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - FIFO pointers and count (empty).
  - State returns to IDLE.
  - mul_start=0, mul_a=0, mul_b=0.
  - out_valid=0, out_product=0.
  - timeout_err=0, jobs_done=0.
  - Wait counter cleared.
  - A reset mid-job discards the job with no output; in_ready=1 after reset.
- FIFO:
  - Push on in_valid & in_ready.
  - Pop only in IDLE (see below).
  - Push and pop in the same cycle are legal; the count is unchanged.
  - No bypass: a pushed entry is visible to IDLE the next cycle.
  - in_ready=0 when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, ARM, RUN.
  - IDLE: if FIFO non-empty and out_valid=0, pop the head into the mul_a/mul_b registers and go to ISSUE. Otherwise stay.
  - ISSUE: mul_start=1 for exactly this cycle; clear the wait counter; go to ARM.
  - ARM: wait for mul_busy=1.
    - If mul_busy=1: clear the counter and go to RUN.
    - Else increment the counter. When the counter reaches TIMEOUT, set timeout_err, drop the job and go to IDLE.
  - RUN: wait for mul_busy=0.
    - On the first cycle mul_busy=0: out_product<=mul_product, out_valid<=1, go to IDLE.
    - Else increment the counter. When it reaches TIMEOUT, set timeout_err, drop the job, go to IDLE.
- mul_a/mul_b change only on the IDLE pop edge. They are held constant through ISSUE, ARM and RUN, and after return to IDLE until the next pop.
- mul_start is 0 in every state except ISSUE.
- Output slot:
  - Single entry.
  - out_valid falls on the edge where out_valid & out_ready.
  - out_product is held until the next capture.
  - Issue is gated by out_valid=0 in IDLE, so a capture never overwrites an unconsumed result.
- jobs_done increments by 1 on each out_valid & out_ready edge; 16'hFFFF wraps to 0.
- timeout_err is cleared only by reset.
- Latency, empty system with out_ready=1:
  - Handshake in cycle C0.
  - IDLE pop at the end of C1.
  - mul_start=1 in C2.
  - out_valid rises the cycle after the first mul_busy=0 sample in RUN.
- Throughput: one job in flight; back-to-back issues are separated by at least one IDLE cycle.

Test Plan:
- Single job: push a=3, b=5 with out_ready=1 → one mul_start pulse in C2; mul_a/mul_b = 3/5 held until busy falls; out_product=64'd15 for one cycle; jobs_done=1.
- Max operands: a=b=32'hFFFFFFFF → out_product=64'hFFFFFFFE00000001; timeout_err=0.
- FIFO fill: 6 back-to-back pushes with out_ready=0:
  - First job completes and stalls in the output slot.
  - in_ready drops after 1+DEPTH=5 accepts.
  - Release out_ready → all 5 products emerge in order; jobs_done=5.
- Backpressure: hold out_ready=0 for 20 cycles after the first result → out_valid and out_product stable, no mul_start issued, FIFO contents retained.
- Timeout: model with mul_busy stuck at 0 → after mul_start, timeout_err=1 within TIMEOUT+1 cycles; no out_valid; the next job is issued from IDLE.
- Reset mid-RUN: assert reset while mul_busy=1 → asynchronously out_valid=0, mul_start=0, in_ready=1, jobs_done=0; a post-reset job of 7×9 yields 64'd63.
